// File: rtl/siso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word intake, LSB-first serial stream with frame strobe.
// Optional even-parity bit after the MSB when SISO_SER_PARITY_EN is defined.
module siso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             Dout,
  output logic             frame,
  output logic             tx_done
);

`ifdef SISO_SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_CNT = CW'(NBITS - 1);

  logic [0:0]       state;
  logic [NBITS-1:0] sreg;
  logic [NBITS-1:0] word;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;

`ifdef SISO_SER_PARITY_EN
  assign word = {^load_data, load_data};
`else
  assign word = load_data;
`endif

  // The final bit of a word frees the serializer, so the next word can chain in gap-free.
  assign last       = (state == SHIFT) && (cnt == LAST_CNT);
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;
  assign tx_done    = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      Dout  <= 1'b0;
      frame <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      sreg  <= word;
      cnt   <= '0;
      Dout  <= word[0];
      frame <= 1'b1;
    end else if (state == SHIFT) begin
      if (last) begin
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
        Dout  <= 1'b0;
        frame <= 1'b0;
      end else begin
        // sreg[0] is already on Dout; present the next bit.
        sreg  <= sreg >> 1;
        Dout  <= sreg[1];
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule
